// File: rtl/i2c_codec_pkg.sv
// Shared types and constants for the I2C codec control-port responder.
package i2c_codec_pkg;

  // Transaction FSM states
  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StByte1,
    StAck1,
    StByte2,
    StAck2,
    StIgnore
  } state_e;

  localparam int unsigned HEAD_L    = 2;
  localparam int unsigned HEAD_R    = 3;
  localparam logic [6:0]  RESET_REG = 7'h0F;
  localparam int unsigned BOTH_BIT  = 8;

  // Power-on contents of the codec shadow registers
  function automatic logic [8:0] reg_default(input int unsigned idx);
    case (idx)
      0, 1:    return 9'h097;
      2, 3:    return 9'h079;
      4:       return 9'h00A;
      5:       return 9'h008;
      6:       return 9'h09F;
      default: return 9'h000;
    endcase
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into iCLK and detects edges plus START/STOP conditions.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic scl_pin,
  input  logic sda_pin,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_hist_q, sda_hist_q;
  logic                   scl_s;

  // Synchronizer chains plus one history flop each; idle bus level is high
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_pin};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_pin};
      scl_hist_q <= scl_s;
      sda_hist_q <= sda_s;
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // SDA edges only count as START/STOP when SCL is steadily high across both samples
  always_comb begin
    scl_rise  = scl_s & ~scl_hist_q;
    scl_fall  = ~scl_s & scl_hist_q;
    start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
    stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;
  end

endmodule

// File: rtl/i2c_codec_responder.sv
// Write-only I2C target emulating the audio codec control port with a shadow register file.
module i2c_codec_responder
  import i2c_codec_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h1A,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NUM_REGS    = 16
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       I2C_SCLK,
  inout  wire        I2C_SDAT,
  output logic       oREG_WE,
  output logic [6:0] oREG_ADDR,
  output logic [8:0] oREG_DATA,
  output logic [6:0] oHEAD_L_VOL,
  output logic [6:0] oHEAD_R_VOL,
  output logic       oBUSY,
  output logic [7:0] oNACK_CNT
);

  logic       scl_rise, scl_fall, sda_s, start_det, stop_det;
  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, byte1_q, byte1_d;
  logic       byte_done, addr_match, commit, nack_inc, sda_drive;
  logic [6:0] c_addr;
  logic [8:0] c_data;
  logic [8:0] regs_q [NUM_REGS];
  logic [8:0] regs_d [NUM_REGS];
  logic       reg_we_q;
  logic [6:0] reg_addr_q;
  logic [8:0] reg_data_q;
  logic [7:0] nack_q;

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .iCLK     (iCLK),
    .iRST_N   (iRST_N),
    .scl_pin  (I2C_SCLK),
    .sda_pin  (I2C_SDAT),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .sda_s    (sda_s),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  assign byte_done  = (bit_cnt_q == 4'd8);
  assign addr_match = (shift_q == {SLAVE_ADDR, 1'b0});
  assign c_addr     = byte1_q[7:1];
  assign c_data     = {byte1_q[0], shift_q};

  // FSM state register
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // FSM next state; bus conditions override every state
  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = StIdle;
    end else if (start_det) begin
      state_d = StAddr;
    end else begin
      case (state_q)
        StAddr:    if (scl_fall && byte_done) state_d = addr_match ? StAddrAck : StIgnore;
        StAddrAck: if (scl_fall) state_d = StByte1;
        StByte1:   if (scl_fall && byte_done) state_d = StAck1;
        StAck1:    if (scl_fall) state_d = StByte2;
        StByte2:   if (scl_fall && byte_done) state_d = StAck2;
        StAck2:    if (scl_fall) state_d = StIgnore;
        default:   state_d = state_q;
      endcase
    end
  end

  // FSM outputs: ACK drive is purely a function of state, so it follows the SCL fall by one cycle
  always_comb begin
    sda_drive = (state_q == StAddrAck) || (state_q == StAck1) || (state_q == StAck2);
    oBUSY     = (state_q != StIdle);
  end

  assign I2C_SDAT = sda_drive ? 1'b0 : 1'bz;

  // Bit shifting and byte-completion events
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    byte1_d   = byte1_q;
    commit    = 1'b0;
    nack_inc  = 1'b0;
    if (start_det || stop_det) begin
      bit_cnt_d = 4'd0;
    end else if (state_q == StAddr || state_q == StByte1 || state_q == StByte2) begin
      if (scl_rise && !byte_done) begin
        shift_d   = {shift_q[6:0], sda_s};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end else if (scl_fall && byte_done) begin
        bit_cnt_d = 4'd0;
        if (state_q == StByte1) byte1_d = shift_q;
        if (state_q == StByte2) commit = 1'b1;
        if (state_q == StAddr && !addr_match) nack_inc = 1'b1;
      end
    end
  end

  // Shadow register file update on commit
  always_comb begin
    regs_d = regs_q;
    if (commit) begin
      if (c_addr == RESET_REG) begin
        for (int i = 0; i < NUM_REGS; i++) regs_d[i] = reg_default(i);
      end else if (32'(c_addr) < NUM_REGS) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (7'(i) == c_addr) regs_d[i] = c_data;
        end
        if (c_data[BOTH_BIT]) begin
          if (c_addr == 7'(HEAD_L)) regs_d[HEAD_R][7:0] = c_data[7:0];
          if (c_addr == 7'(HEAD_R)) regs_d[HEAD_L][7:0] = c_data[7:0];
        end
      end
    end
  end

  // Datapath and status registers
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'd0;
      byte1_q    <= 8'd0;
      reg_we_q   <= 1'b0;
      reg_addr_q <= 7'd0;
      reg_data_q <= 9'd0;
      nack_q     <= 8'd0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= reg_default(i);
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      byte1_q   <= byte1_d;
      reg_we_q  <= commit;
      regs_q    <= regs_d;
      if (commit) begin
        reg_addr_q <= c_addr;
        reg_data_q <= c_data;
      end
      if (nack_inc && nack_q != 8'hFF) nack_q <= nack_q + 8'd1;
    end
  end

  assign oREG_WE     = reg_we_q;
  assign oREG_ADDR   = reg_addr_q;
  assign oREG_DATA   = reg_data_q;
  assign oHEAD_L_VOL = regs_q[HEAD_L][6:0];
  assign oHEAD_R_VOL = regs_q[HEAD_R][6:0];
  assign oNACK_CNT   = nack_q;

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Bench for i2c_codec_responder: bit-banged I2C master, reference register model, strobe scoreboard.
module tb_i2c_codec_responder;

  localparam int Q = 10;  // iCLK cycles per quarter SCL period

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl = 1'b1;
  logic m_low = 1'b0;
  wire  sda;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  logic       reg_we, busy;
  logic [6:0] reg_addr, head_l, head_r;
  logic [8:0] reg_data;
  logic [7:0] nack_cnt;

  i2c_codec_responder dut (
    .iCLK       (clk),
    .iRST_N     (rst_n),
    .I2C_SCLK   (scl),
    .I2C_SDAT   (sda),
    .oREG_WE    (reg_we),
    .oREG_ADDR  (reg_addr),
    .oREG_DATA  (reg_data),
    .oHEAD_L_VOL(head_l),
    .oHEAD_R_VOL(head_r),
    .oBUSY      (busy),
    .oNACK_CNT  (nack_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic [6:0] a;
    logic [8:0] d;
    logic [6:0] l;
    logic [6:0] r;
  } exp_t;

  exp_t       sb[$];
  logic [8:0] model[16];
  int         model_nack = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [8:0] dflt(input int i);
    logic [8:0] tbl[7];
    tbl = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A, 9'h008, 9'h09F};
    return (i < 7) ? tbl[i] : 9'h000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model[i] = dflt(i);
  endtask

  // Reference behaviour of one accepted word, plus the strobe the DUT must present
  task automatic model_commit(input logic [6:0] a, input logic [8:0] d);
    exp_t e;
    if (a == 7'h0F) begin
      model_reset();
    end else if (a < 7'd16) begin
      model[a[3:0]] = d;
      if (d[8] && a == 7'd2) model[3][7:0] = d[7:0];
      if (d[8] && a == 7'd3) model[2][7:0] = d[7:0];
    end
    e.a = a;
    e.d = d;
    e.l = model[2][6:0];
    e.r = model[3][6:0];
    sb.push_back(e);
  endtask

  task automatic check_file(input string tag);
    for (int i = 0; i < 16; i++) check($sformatf("%s reg%0d", tag, i), 32'(dut.regs_q[i]), 32'(model[i]));
  endtask

  // Monitor: every strobe must match the oldest expected word
  always @(negedge clk) begin
    if (rst_n && reg_we) begin
      if (sb.size() == 0) begin
        check("spurious strobe", 32'(reg_we), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("strobe addr", 32'(reg_addr), 32'(e.a));
        check("strobe data", 32'(reg_data), 32'(e.d));
        check("head_l vol", 32'(head_l), 32'(e.l));
        check("head_r vol", 32'(head_r), 32'(e.r));
      end
    end
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic wbit(input logic b);
    m_low = !b;
    wait_q();
    scl = 1'b1;
    wait_q();
    wait_q();
    scl = 1'b0;
    wait_q();
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) wbit(b[i]);
    m_low = 1'b0;
    wait_q();
    scl = 1'b1;
    wait_q();
    ack = !sda;
    wait_q();
    scl = 1'b0;
    wait_q();
  endtask

  task automatic i2c_start();
    m_low = 1'b0;
    wait_q();
    scl = 1'b1;
    wait_q();
    m_low = 1'b1;
    wait_q();
    scl = 1'b0;
    wait_q();
  endtask

  task automatic i2c_stop();
    m_low = 1'b1;
    wait_q();
    scl = 1'b1;
    wait_q();
    m_low = 1'b0;
    wait_q();
  endtask

  // Full transaction of n bytes with START/STOP; ACK expectations follow the protocol rules
  task automatic xfer(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                      input logic [7:0] b3, input int n, input string tag);
    logic [7:0] bs[4];
    logic       ack, match;
    bs    = '{b0, b1, b2, b3};
    match = (b0 == 8'h34);
    i2c_start();
    check({tag, " busy"}, 32'(busy), 32'd1);
    if (!match && model_nack < 255) model_nack++;
    for (int k = 0; k < n; k++) begin
      if (k == 2 && match) model_commit(bs[1][7:1], {bs[1][0], bs[2]});
      wbyte(bs[k], ack);
      check($sformatf("%s ack%0d", tag, k), 32'(ack), 32'(match && k < 3));
    end
    i2c_stop();
    check({tag, " idle"}, 32'(busy), 32'd0);
    check({tag, " nack_cnt"}, 32'(nack_cnt), 32'(model_nack));
  endtask

  initial begin
    logic ack;
    model_reset();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    check("rst we", 32'(reg_we), 32'd0);
    check("rst addr", 32'(reg_addr), 32'd0);
    check("rst data", 32'(reg_data), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst nack", 32'(nack_cnt), 32'd0);
    check("rst head_l", 32'(head_l), 32'h79);
    check("rst head_r", 32'(head_r), 32'h79);
    check("rst sda", 32'(sda), 32'd1);

    xfer(8'h34, 8'h04, 8'hFA, 8'h00, 3, "w_reg2");
    xfer(8'h34, 8'h05, 8'hD0, 8'h00, 3, "w_both");
    check_file("both");

    // Wrong address then read bit, across a repeated START
    i2c_start();
    wbyte(8'h36, ack);
    check("addr36 ack", 32'(ack), 32'd0);
    i2c_start();
    wbyte(8'h35, ack);
    check("addr35 ack", 32'(ack), 32'd0);
    model_nack += 2;
    check("nack busy", 32'(busy), 32'd1);
    i2c_stop();
    check("nack idle", 32'(busy), 32'd0);
    check("nack cnt", 32'(nack_cnt), 32'(model_nack));

    xfer(8'h34, 8'h1E, 8'h00, 8'h00, 3, "w_reset");
    check_file("reset_reg");

    // Partial word terminated by STOP
    xfer(8'h34, 8'h04, 8'h00, 8'h00, 2, "partial");
    check_file("partial");

    // Repeated START in the middle of the data byte discards the word
    i2c_start();
    wbyte(8'h34, ack);
    check("rs ack0", 32'(ack), 32'd1);
    wbyte(8'h04, ack);
    check("rs ack1", 32'(ack), 32'd1);
    for (int i = 0; i < 4; i++) wbit(1'(i));
    xfer(8'h34, 8'h06, 8'h12, 8'h00, 3, "after_rs");

    xfer(8'h34, 8'h04, 8'h10, 8'h55, 4, "four_byte");

    for (int t = 0; t < 10; t++) begin
      logic [7:0] a0;
      logic [6:0] ra;
      logic [8:0] dv;
      a0 = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h34;
      ra = 7'($urandom_range(0, 19));
      dv = 9'($urandom);
      xfer(a0, {ra, dv[8]}, dv[7:0], 8'($urandom), $urandom_range(3, 4), $sformatf("rnd%0d", t));
    end
    check_file("random");

    // Reset while the DUT is holding an ACK low
    xfer(8'h34, 8'h04, 8'h33, 8'h00, 3, "pre_rst");
    i2c_start();
    for (int i = 7; i >= 0; i--) wbit(i == 0 ? 1'b0 : 1'(8'h34 >> i));
    m_low = 1'b0;
    wait_q();
    check("ack before reset", 32'(sda), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("sda released on reset", 32'(sda), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    model_nack = 0;
    check("post-rst busy", 32'(busy), 32'd0);
    check("post-rst nack", 32'(nack_cnt), 32'd0);
    check("post-rst head_l", 32'(head_l), 32'h79);
    scl = 1'b1;
    wait_q();
    scl = 1'b0;
    wait_q();
    wbyte(8'h04, ack);
    check("no ack after reset", 32'(ack), 32'd0);
    i2c_stop();
    check_file("post_rst");

    repeat (10) @(negedge clk);
    check("pending strobes", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
